// File: rtl/qei_pkg.sv
// Shared definitions for the quadrature encoder interface.
// Gray-state constants, default counter width, step lookup.
package qei_pkg;

    localparam int COUNT_W_DEF = 16;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    // Successor of an {A,B} state when turning forward.
    function automatic logic [1:0] next_fwd(input logic [1:0] s);
        logic [1:0] n;
        n = S00;
        unique case (s)
            S00: n = S01;
            S01: n = S11;
            S11: n = S10;
            S10: n = S00;
            default: n = S00;
        endcase
        return n;
    endfunction

    // Successor of an {A,B} state when turning backward.
    function automatic logic [1:0] next_bwd(input logic [1:0] s);
        logic [1:0] n;
        n = S00;
        unique case (s)
            S00: n = S10;
            S10: n = S11;
            S11: n = S01;
            S01: n = S00;
            default: n = S00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qei_decoder.sv
// x4 quadrature step decoder, purely combinational.
// No change and double-bit jumps both yield no step.
module qei_decoder
    import qei_pkg::*;
(
    input  logic [1:0] prev_ab,
    input  logic [1:0] cur_ab,
    output logic       inc,
    output logic       dec
);

    // Classify the transition by matching against each neighbour state.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        if (prev_ab != cur_ab) begin
            inc = (cur_ab == next_fwd(prev_ab));
            dec = (cur_ab == next_bwd(prev_ab));
        end
    end

endmodule

// File: rtl/tt_um_jakedrew_qei.sv
// Tiny Tapeout tile: quadrature encoder interface.
// Synchronised A/B, x4 decode, up/down count and direction on the pins.
module tt_um_jakedrew_qei
    import qei_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = COUNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             cur_ab;
    logic [1:0]             prev_ab;
    logic                   inc;
    logic                   dec;
    logic [COUNT_W-1:0]     count;
    logic                   dir;
    logic                   unused_ok;

    // Shift raw encoder pins through the synchroniser chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], ui_in[0]};
            sync_b <= {sync_b[SYNC_STAGES-2:0], ui_in[1]};
        end
    end

    assign cur_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    qei_decoder u_dec (
        .prev_ab (prev_ab),
        .cur_ab  (cur_ab),
        .inc     (inc),
        .dec     (dec)
    );

    // Track last state and apply the decoded step to count and dir.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab <= S00;
            count   <= '0;
            dir     <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            if (inc) begin
                count <= count + ONE;
                dir   <= 1'b1;
            end else if (dec) begin
                count <= count - ONE;
                dir   <= 1'b0;
            end
        end
    end

    assign uo_out  = {dir, count[6:0]};
    assign uio_out = count[14:7];
    assign uio_oe  = 8'hFF;

    assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in};

endmodule

// File: tb/tb_tt_um_jakedrew_qei.sv
// Self-checking bench for the quadrature encoder tile.
// Independent Gray-index model feeds a scoreboard of expected count/dir.
module tb_tt_um_jakedrew_qei;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_jakedrew_qei dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cnt;
        logic        dir;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mcnt;
    logic        mdir;
    logic [1:0]  mprev;

    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        mcnt  = 16'h0000;
        mdir  = 1'b0;
        mprev = 2'b00;
        sb.delete();
    endtask

    // Drive one A/B level, update the model, push expectation, let it settle.
    task automatic drive_ab(input logic a, input logic b);
        logic [1:0] n;
        int         d;
        n = {a, b};
        d = (gidx(n) - gidx(mprev) + 4) % 4;
        if (d == 1) begin
            mcnt = mcnt + 16'd1;
            mdir = 1'b1;
        end else if (d == 3) begin
            mcnt = mcnt - 16'd1;
            mdir = 1'b0;
        end
        mprev = n;
        ui_in[0] = a;
        ui_in[1] = b;
        sb.push_back(exp_t'{cnt: mcnt, dir: mdir});
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (16) @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out got %h want 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out got %h want 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hFF) begin
            errors++;
            $display("FAIL reset_uio_oe got %h want FF", uio_oe);
        end
    endtask

    // Pin change must appear on exactly the third rising edge.
    task automatic test_latency();
        ui_in[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut.count !== 16'h0000) begin
            errors++;
            $display("FAIL latency_early got %h want 0000", dut.count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'h81) begin
            errors++;
            $display("FAIL latency_edge3 got %h want 81", uo_out);
        end
        repeat (10) @(posedge clk);
        mprev = 2'b01;
        mcnt  = 16'h0001;
        mdir  = 1'b1;
        #1;
        drive_ab(1'b0, 1'b0);
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({dut.count, uo_out} !== {e.cnt, e.dir, e.cnt[6:0]}) begin
                errors++;
                $display("FAIL latency_back got %h/%h want %h/%b",
                         dut.count, uo_out, e.cnt, e.dir);
            end
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            drive_ab(seq[i][1], seq[i][0]);
            e = sb.pop_front();
            checks++;
            if ({dut.count, uo_out, uio_out} !==
                {e.cnt, e.dir, e.cnt[6:0], e.cnt[14:7]}) begin
                errors++;
                $display("FAIL fwd_step%0d count=%h uo=%h want count=%h dir=%b",
                         i, dut.count, uo_out, e.cnt, e.dir);
            end
        end
        checks++;
        if (dut.count !== 16'd4) begin
            errors++;
            $display("FAIL fwd_total got %h want 0004", dut.count);
        end
    endtask

    task automatic test_backward();
        logic [1:0] seq [4];
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            drive_ab(seq[i][1], seq[i][0]);
            e = sb.pop_front();
            checks++;
            if ({dut.count, uo_out, uio_out} !==
                {e.cnt, e.dir, e.cnt[6:0], e.cnt[14:7]}) begin
                errors++;
                $display("FAIL bwd_step%0d count=%h uo=%h want count=%h dir=%b",
                         i, dut.count, uo_out, e.cnt, e.dir);
            end
        end
        checks++;
        if (dut.count !== 16'd0) begin
            errors++;
            $display("FAIL bwd_total got %h want 0000", dut.count);
        end
    endtask

    // Full Gray cycles; fwd=1 for forward. Checks each cycle end.
    task automatic run_cycles(input int n, input logic fwd, input string tag);
        logic [1:0] f [4];
        logic [1:0] b [4];
        f = '{2'b01, 2'b11, 2'b10, 2'b00};
        b = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int c = 0; c < n; c++) begin
            exp_t e;
            for (int k = 0; k < 4; k++) begin
                if (fwd) drive_ab(f[k][1], f[k][0]);
                else     drive_ab(b[k][1], b[k][0]);
            end
            repeat (3) void'(sb.pop_front());
            e = sb.pop_front();
            checks++;
            if ({dut.count, uo_out, uio_out} !==
                {e.cnt, e.dir, e.cnt[6:0], e.cnt[14:7]}) begin
                errors++;
                $display("FAIL %s_cyc%0d count=%h uo=%h uio=%h want %h dir=%b",
                         tag, c, dut.count, uo_out, uio_out, e.cnt, e.dir);
            end
        end
    endtask

    task automatic test_multi_forward();
        logic [14:0] pin0;
        run_cycles(8, 1'b1, "fwd8");
        checks++;
        if (uo_out[6:0] !== 7'd32) begin
            errors++;
            $display("FAIL fwd8_delta got %0d want 32", uo_out[6:0]);
        end
        pin0 = {uio_out, uo_out[6:0]};
        run_cycles(64, 1'b1, "fwd64");
        checks++;
        if (({uio_out, uo_out[6:0]} - pin0) !== 15'd256) begin
            errors++;
            $display("FAIL fwd64_delta got %0d want 256",
                     {uio_out, uo_out[6:0]} - pin0);
        end
    endtask

    task automatic test_backward_wrap();
        exp_t e;
        run_cycles(64, 1'b0, "bwd64");
        checks++;
        if (dut.count !== 16'd32) begin
            errors++;
            $display("FAIL bwd64_total got %h want 0020", dut.count);
        end
        run_cycles(8, 1'b0, "bwd8");
        drive_ab(1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (dut.count !== 16'hFFFF || e.cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_count got %h want FFFF", dut.count);
        end
        checks++;
        if (uo_out !== 8'h7F || uio_out !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_pins got uo=%h uio=%h want 7F FF", uo_out, uio_out);
        end
        drive_ab(1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({dut.count, uo_out} !== {e.cnt, e.dir, e.cnt[6:0]}) begin
            errors++;
            $display("FAIL wrap_up got %h/%h want %h", dut.count, uo_out, e.cnt);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        drive_ab(1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({dut.count, uo_out} !== {e.cnt, e.dir, e.cnt[6:0]}) begin
            errors++;
            $display("FAIL illegal_jump got %h/%h want %h dir=%b",
                     dut.count, uo_out, e.cnt, e.dir);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ({dut.count, uo_out[7]} !== {mcnt, mdir}) begin
            errors++;
            $display("FAIL illegal_idle got %h dir=%b want %h dir=%b",
                     dut.count, uo_out[7], mcnt, mdir);
        end
        drive_ab(1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({dut.count, uo_out} !== {e.cnt, e.dir, e.cnt[6:0]}) begin
            errors++;
            $display("FAIL illegal_back got %h/%h want %h", dut.count, uo_out, e.cnt);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_ab(1'b0, 1'b1);
        drive_ab(1'b1, 1'b1);
        void'(sb.pop_front());
        e = sb.pop_front();
        checks++;
        if (dut.count !== e.cnt) begin
            errors++;
            $display("FAIL pre_reset got %h want %h", dut.count, e.cnt);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || dut.count !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset got uo=%h uio=%h count=%h want 0",
                     uo_out, uio_out, dut.count);
        end
        ui_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        drive_ab(1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({dut.count, uo_out} !== {e.cnt, e.dir, e.cnt[6:0]}) begin
            errors++;
            $display("FAIL post_reset got %h/%h want %h", dut.count, uo_out, e.cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_forward();
        test_backward();
        test_multi_forward();
        test_backward_wrap();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
